// File: rtl/usb_rx_unstuff_deser_pkg.sv
// Shared USB receive-path constants and types.
package usb_rx_pkg;

  // Ones in a row after which the transmitter must insert a zero
  localparam int USB_BIT_STUFF_RUN = 6;
  // Natural deserialized word width (one byte)
  localparam int USB_WORD_WIDTH = 8;

  typedef logic [USB_WORD_WIDTH-1:0] usb_word_t;

endpackage

// File: rtl/usb_rx_unstuff_deser_stuff_run_detector.sv
// Run-of-ones tracker: flags the slot where a stuffed zero is due and a
// violation when a one arrives in that slot instead.
module usb_stuff_run_detector
  import usb_rx_pkg::*;
#(
  parameter int RUN_LENGTH = USB_BIT_STUFF_RUN
) (
  input  logic clk12,
  input  logic RST,
  input  logic i_clear,
  input  logic i_valid,
  input  logic i_data,
  output logic o_is_stuff_slot,
  output logic o_violation
);

  localparam int CW = $clog2(RUN_LENGTH + 2);
  localparam logic [CW-1:0] RUN_STUFF = CW'(RUN_LENGTH);
  localparam logic [CW-1:0] RUN_SAT   = CW'(RUN_LENGTH + 1);

  logic [CW-1:0] r_run;

  // Count consecutive accepted ones, clear on a zero, saturate one past the limit
  always_ff @(posedge clk12) begin
    if (RST) begin
      r_run <= '0;
    end else if (i_clear) begin
      r_run <= '0;
    end else if (i_valid) begin
      if (!i_data) begin
        r_run <= '0;
      end else if (r_run != RUN_SAT) begin
        r_run <= r_run + CW'(1);
      end
    end
  end

  assign o_is_stuff_slot = (r_run == RUN_STUFF);
  assign o_violation     = i_valid & i_data & o_is_stuff_slot;

endmodule

// File: rtl/usb_rx_unstuff_deser.sv
// USB receive bit unstuffer and LSB-first deserializer.
// Optional macro USB_UNSTUFF_STATS_EN adds o_stuff_bit_total, a saturating
// count of removed stuff bits that only RST clears.
module usb_rx_unstuff_deser
  import usb_rx_pkg::*;
#(
  parameter int RUN_LENGTH = USB_BIT_STUFF_RUN,
  parameter int WORD_WIDTH = USB_WORD_WIDTH
) (
  input  logic                          clk12,
  input  logic                          RST,
  input  logic                          i_in_valid,
  input  logic                          i_in_data,
  input  logic                          i_frame_active,
  output logic [WORD_WIDTH-1:0]         o_word_out,
  output logic                          o_word_valid,
  output logic                          o_stuff_dropped,
  output logic                          o_stuff_error,
  output logic [$clog2(WORD_WIDTH)-1:0] o_bit_count
`ifdef USB_UNSTUFF_STATS_EN
  ,
  output logic [15:0]                   o_stuff_bit_total
`endif
);

  localparam int BCW = $clog2(WORD_WIDTH);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] r_word_out;
  logic                  r_word_valid;
  logic                  r_stuff_dropped;
  logic                  r_stuff_error;
  logic [BCW-1:0]        r_bit_count;
  // Only WORD_WIDTH-1 bits are buffered; the final bit goes straight to the word
  logic [WORD_WIDTH-2:0] r_shreg;

  logic                  w_frame_clear;
  logic                  w_accept;
  logic                  w_is_stuff_slot;
  logic                  w_violation;
  logic                  w_shift;
  logic                  w_drop;
  logic                  w_word_done;
  logic [WORD_WIDTH-2:0] w_shreg_next;

  // Bits are ignored outside a frame and after a stuffing violation
  assign w_frame_clear = ~i_frame_active;
  assign w_accept      = i_in_valid & i_frame_active & ~r_stuff_error;

  usb_stuff_run_detector #(
    .RUN_LENGTH(RUN_LENGTH)
  ) u_run_det (
    .clk12          (clk12),
    .RST            (RST),
    .i_clear        (w_frame_clear),
    .i_valid        (w_accept),
    .i_data         (i_in_data),
    .o_is_stuff_slot(w_is_stuff_slot),
    .o_violation    (w_violation)
  );

  assign w_shift     = w_accept & ~w_is_stuff_slot;
  assign w_drop      = w_accept & w_is_stuff_slot & ~i_in_data;
  assign w_word_done = w_shift & (r_bit_count == BC_LAST);

  // New bit enters at the top and older bits move toward bit 0
  for (genvar gi = 0; gi < WORD_WIDTH - 1; gi++) begin : g_shift
    if (gi == WORD_WIDTH - 2) begin : g_top
      assign w_shreg_next[gi] = i_in_data;
    end else begin : g_mid
      assign w_shreg_next[gi] = r_shreg[gi+1];
    end
  end

  // Partial-word datapath and frame-scoped status
  always_ff @(posedge clk12) begin
    if (RST) begin
      r_shreg       <= '0;
      r_bit_count   <= '0;
      r_stuff_error <= 1'b0;
    end else if (w_frame_clear) begin
      r_shreg       <= '0;
      r_bit_count   <= '0;
      r_stuff_error <= 1'b0;
    end else begin
      if (w_violation) begin
        r_stuff_error <= 1'b1;
      end
      if (w_shift) begin
        r_shreg     <= w_shreg_next;
        r_bit_count <= w_word_done ? '0 : r_bit_count + BCW'(1);
      end
    end
  end

  // Completed word and single-cycle event pulses; the word survives frame end
  always_ff @(posedge clk12) begin
    if (RST) begin
      r_word_out      <= '0;
      r_word_valid    <= 1'b0;
      r_stuff_dropped <= 1'b0;
    end else begin
      r_word_valid    <= w_word_done;
      r_stuff_dropped <= w_drop;
      if (w_word_done) begin
        r_word_out <= {i_in_data, r_shreg};
      end
    end
  end

  assign o_word_out      = r_word_out;
  assign o_word_valid    = r_word_valid;
  assign o_stuff_dropped = r_stuff_dropped;
  assign o_stuff_error   = r_stuff_error;
  assign o_bit_count     = r_bit_count;

`ifdef USB_UNSTUFF_STATS_EN
  logic [15:0] r_stuff_bit_total;

  // Lifetime count of removed stuff bits, saturating, survives frame boundaries
  always_ff @(posedge clk12) begin
    if (RST) begin
      r_stuff_bit_total <= '0;
    end else if (w_drop && (r_stuff_bit_total != 16'hFFFF)) begin
      r_stuff_bit_total <= r_stuff_bit_total + 16'd1;
    end
  end

  assign o_stuff_bit_total = r_stuff_bit_total;
`endif

endmodule
